// File: rtl/dgclk_pkg.sv
// Shared definitions for the digital clock: controller state encoding
// and the field limits/widths used by the controller and time counter.
package dgclk_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2
   } state_t;

   localparam int HR_MAX  = 23;
   localparam int MIN_MAX = 59;
   localparam int SEC_MAX = 59;

   localparam int HR_W  = 5;
   localparam int MIN_W = 6;
   localparam int SEC_W = 6;

endpackage

// File: rtl/dgclk_prescaler.sv
// Free-running modulo-DIV counter with a synchronous clear.
// wrap flags the last count of each period (cnt == DIV-1).
module dgclk_prescaler #(
   parameter  int DIV = 50000000,
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          wrap
);

   logic [CW-1:0] cnt_reg;

   assign cnt  = cnt_reg;
   assign wrap = (cnt_reg == CW'(DIV - 1));

   // Count 0..DIV-1 and wrap explicitly; clear restarts the period at 0.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_reg <= '0;
      end else if (wrap) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CW'(1);
      end
   end

endmodule

// File: rtl/dgclk_ctrl.sv
// Mode/edit controller for the digital clock: produces the 1 Hz advance
// enable in RUN, lets the user edit hours then minutes with two buttons,
// and commits the edited time with a one-cycle load strobe. An edit left
// idle for TIMEOUT_S seconds is abandoned without loading.
module dgclk_ctrl
   import dgclk_pkg::*;
#(
   parameter int CLK_DIV   = 50000000,
   parameter int TIMEOUT_S = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_mode,
   input  logic             btn_inc,
   input  logic [HR_W-1:0]  cur_hr,
   input  logic [MIN_W-1:0] cur_min,
   output logic             sec_tick,
   output logic             load,
   output logic [HR_W-1:0]  ld_hr,
   output logic [MIN_W-1:0] ld_min,
   output logic [1:0]       mode,
   output logic             blink
);

   localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDLE_W = $clog2(TIMEOUT_S + 1);

   state_t             state_reg, state_next;
   logic [HR_W-1:0]    edit_hr_reg, edit_hr_next;
   logic [MIN_W-1:0]   edit_min_reg, edit_min_next;
   logic [IDLE_W-1:0]  idle_cnt_reg, idle_cnt_next;
   logic               load_reg, load_next;
   logic [HR_W-1:0]    ld_hr_reg, ld_hr_next;
   logic [MIN_W-1:0]   ld_min_reg, ld_min_next;
   logic               btn_mode_prev_reg, btn_inc_prev_reg;

   logic [CNT_W-1:0]   cnt;
   logic               wrap;
   logic               mode_press, inc_press, timeout, state_change;

   // Period restarts on every state change so RUN always begins at cnt 0,
   // which keeps the first tick away from the load cycle.
   dgclk_prescaler #(
      .DIV (CLK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_change),
      .cnt  (cnt),
      .wrap (wrap)
   );

   assign mode_press   = btn_mode & ~btn_mode_prev_reg;
   assign inc_press    = btn_inc & ~btn_inc_prev_reg;
   assign timeout      = wrap && (idle_cnt_reg == IDLE_W'(TIMEOUT_S - 1));
   assign state_change = (state_next != state_reg);

   assign sec_tick = (state_reg == RUN) && wrap;
   assign blink    = (state_reg != RUN) && (cnt < CNT_W'(CLK_DIV / 2));
   assign mode     = state_reg;
   assign load     = load_reg;
   assign ld_hr    = ld_hr_reg;
   assign ld_min   = ld_min_reg;

   // State, edit buffer, idle timer, load strobe and button history.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= RUN;
         edit_hr_reg       <= '0;
         edit_min_reg      <= '0;
         idle_cnt_reg      <= '0;
         load_reg          <= 1'b0;
         ld_hr_reg         <= '0;
         ld_min_reg        <= '0;
         btn_mode_prev_reg <= 1'b0;
         btn_inc_prev_reg  <= 1'b0;
      end else begin
         state_reg         <= state_next;
         edit_hr_reg       <= edit_hr_next;
         edit_min_reg      <= edit_min_next;
         idle_cnt_reg      <= idle_cnt_next;
         load_reg          <= load_next;
         ld_hr_reg         <= ld_hr_next;
         ld_min_reg        <= ld_min_next;
         btn_mode_prev_reg <= btn_mode;
         btn_inc_prev_reg  <= btn_inc;
      end
   end

   // Next state and edits; mode press beats timeout, which beats inc press.
   always_comb begin
      state_next    = state_reg;
      edit_hr_next  = edit_hr_reg;
      edit_min_next = edit_min_reg;
      load_next     = 1'b0;
      ld_hr_next    = '0;
      ld_min_next   = '0;
      case (state_reg)
         RUN: begin
            if (mode_press) begin
               state_next    = SET_HR;
               edit_hr_next  = cur_hr;
               edit_min_next = cur_min;
            end
         end
         SET_HR: begin
            if (mode_press) begin
               state_next = SET_MIN;
            end else if (timeout) begin
               state_next = RUN;
            end else if (inc_press) begin
               edit_hr_next = (edit_hr_reg == HR_W'(HR_MAX)) ? '0
                                                             : edit_hr_reg + HR_W'(1);
            end
         end
         SET_MIN: begin
            if (mode_press) begin
               state_next  = RUN;
               load_next   = 1'b1;
               ld_hr_next  = edit_hr_reg;
               ld_min_next = edit_min_reg;
            end else if (timeout) begin
               state_next = RUN;
            end else if (inc_press) begin
               edit_min_next = (edit_min_reg == MIN_W'(MIN_MAX)) ? '0
                                                                 : edit_min_reg + MIN_W'(1);
            end
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   // Idle timer counts whole seconds without a press while editing.
   always_comb begin
      idle_cnt_next = idle_cnt_reg;
      if (state_change || (state_reg == RUN)) begin
         idle_cnt_next = '0;
      end else if (mode_press || inc_press) begin
         idle_cnt_next = '0;
      end else if (wrap) begin
         idle_cnt_next = (idle_cnt_reg == IDLE_W'(TIMEOUT_S)) ? '0
                                                              : idle_cnt_reg + IDLE_W'(1);
      end
   end

endmodule

// File: tb/tb_dgclk_ctrl.sv
// Self-checking bench for dgclk_ctrl with CLK_DIV=4, TIMEOUT_S=3.
// Directed scenarios use hand-derived constants; the randomized run is
// compared cycle by cycle against a behavioural model of the clock rules.
module tb_dgclk_ctrl;

   localparam int CLK_DIV   = 4;
   localparam int TIMEOUT_S = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [4:0] cur_hr = 5'd0;
   logic [5:0] cur_min = 6'd0;
   logic       sec_tick;
   logic       load;
   logic [4:0] ld_hr;
   logic [5:0] ld_min;
   logic [1:0] mode;
   logic       blink;

   int n_checks = 0;
   int n_fails  = 0;

   // Behavioural model: mode number, cycles spent in the mode, seconds
   // without a press, edit values and the registered load output.
   int m_mode, m_age, m_idle, m_hr, m_min, m_ld_hr, m_ld_min;
   bit m_load, m_pm, m_pi;

   logic [15:0] got;
   assign got = {sec_tick, load, ld_hr, ld_min, mode, blink};

   dgclk_ctrl #(
      .CLK_DIV   (CLK_DIV),
      .TIMEOUT_S (TIMEOUT_S)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_mode (btn_mode),
      .btn_inc  (btn_inc),
      .cur_hr   (cur_hr),
      .cur_min  (cur_min),
      .sec_tick (sec_tick),
      .load     (load),
      .ld_hr    (ld_hr),
      .ld_min   (ld_min),
      .mode     (mode),
      .blink    (blink)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got=none required=finish");
      $fatal(1, "watchdog");
   end

   // Apply one clock edge to the model using the inputs the DUT also sees.
   task automatic model_edge();
      bit mp, ip, wr;
      int nm;
      if (rst) begin
         m_mode = 0; m_age = 0; m_idle = 0; m_hr = 0; m_min = 0;
         m_load = 0; m_ld_hr = 0; m_ld_min = 0; m_pm = 0; m_pi = 0;
      end else begin
         mp = btn_mode && !m_pm;
         ip = btn_inc && !m_pi;
         wr = (m_age % CLK_DIV) == CLK_DIV - 1;
         nm = m_mode;
         m_load = 0; m_ld_hr = 0; m_ld_min = 0;
         if (m_mode == 0) begin
            if (mp) begin
               nm = 1; m_hr = int'(cur_hr); m_min = int'(cur_min);
            end
         end else if (mp) begin
            if (m_mode == 1) nm = 2;
            else begin
               nm = 0; m_load = 1; m_ld_hr = m_hr; m_ld_min = m_min;
            end
         end else if (wr && (m_idle + 1 >= TIMEOUT_S)) begin
            nm = 0;
         end else if (ip) begin
            if (m_mode == 1) m_hr = (m_hr + 1) % 24;
            else             m_min = (m_min + 1) % 60;
         end
         if (nm != m_mode || nm == 0) m_idle = 0;
         else if (mp || ip)           m_idle = 0;
         else if (wr)                 m_idle = m_idle + 1;
         m_age  = (nm != m_mode) ? 0 : m_age + 1;
         m_mode = nm;
         m_pm   = btn_mode;
         m_pi   = btn_inc;
      end
   endtask

   function automatic logic [15:0] model_out();
      int   ph;
      logic t, b;
      ph = m_age % CLK_DIV;
      t  = (m_mode == 0) && (ph == CLK_DIV - 1);
      b  = (m_mode != 0) && (ph < CLK_DIV / 2);
      return {t, m_load, 5'(m_ld_hr), 6'(m_ld_min), 2'(m_mode), b};
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic press_mode();
      btn_mode = 1'b1; step();
      btn_mode = 1'b0; step();
   endtask

   task automatic press_inc();
      btn_inc = 1'b1; step();
      btn_inc = 1'b0; step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_checks++;
      if (got !== 16'h0000) begin
         n_fails++;
         $display("FAIL reset_outputs: got=%h required=%h", got, 16'h0000);
      end
      n_checks++;
      if (got !== model_out()) begin
         n_fails++;
         $display("FAIL reset_model: got=%h required=%h", got, model_out());
      end
      rst = 1'b0;
   endtask

   task automatic test_idle_ticks();
      logic [12:0] mask;
      logic        other;
      mask  = '0;
      other = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         mask[c] = sec_tick;
         if (load || (mode != 2'd0) || blink) other = 1'b1;
         step();
      end
      n_checks++;
      if (mask !== 13'b1_0001_0001_0000) begin
         n_fails++;
         $display("FAIL idle_tick_cycles: got=%b required=%b", mask, 13'b1_0001_0001_0000);
      end
      n_checks++;
      if (other !== 1'b0) begin
         n_fails++;
         $display("FAIL idle_quiet: got=%b required=0", other);
      end
   endtask

   task automatic test_edit_sequence();
      cur_hr = 5'd22; cur_min = 6'd58;
      press_mode();
      n_checks++;
      if ({mode, load} !== {2'd1, 1'b0}) begin
         n_fails++;
         $display("FAIL edit_enter_hr: got mode=%0d load=%b required mode=1 load=0", mode, load);
      end
      repeat (3) press_inc();
      press_mode();
      n_checks++;
      if ({mode, load} !== {2'd2, 1'b0}) begin
         n_fails++;
         $display("FAIL edit_enter_min: got mode=%0d load=%b required mode=2 load=0", mode, load);
      end
      repeat (2) press_inc();
      btn_mode = 1'b1;
      step();
      n_checks++;
      if ({sec_tick, load, ld_hr, ld_min, mode} !== {1'b0, 1'b1, 5'd1, 6'd0, 2'd0}) begin
         n_fails++;
         $display("FAIL edit_load: got tick=%b load=%b hr=%0d min=%0d mode=%0d required tick=0 load=1 hr=1 min=0 mode=0",
                  sec_tick, load, ld_hr, ld_min, mode);
      end
      btn_mode = 1'b0;
      step();
      n_checks++;
      if ({load, ld_hr, ld_min} !== 12'd0) begin
         n_fails++;
         $display("FAIL edit_load_drop: got load=%b hr=%0d min=%0d required 0 0 0", load, ld_hr, ld_min);
      end
   endtask

   task automatic test_held_inc();
      cur_hr = 5'd5; cur_min = 6'd10;
      press_mode();
      btn_inc = 1'b1;
      repeat (10) step();
      btn_inc = 1'b0;
      // Timeout is due on this edge; the mode press must take priority.
      press_mode();
      n_checks++;
      if (mode !== 2'd2) begin
         n_fails++;
         $display("FAIL held_mode_beats_timeout: got mode=%0d required 2", mode);
      end
      btn_mode = 1'b1;
      step();
      n_checks++;
      if ({load, ld_hr, ld_min} !== {1'b1, 5'd6, 6'd10}) begin
         n_fails++;
         $display("FAIL held_inc_once: got load=%b hr=%0d min=%0d required load=1 hr=6 min=10", load, ld_hr, ld_min);
      end
      btn_mode = 1'b0;
      step();
   endtask

   task automatic test_same_cycle();
      cur_hr = 5'd7; cur_min = 6'd30;
      press_mode();
      press_mode();
      btn_mode = 1'b1; btn_inc = 1'b1;
      step();
      n_checks++;
      if ({load, ld_hr, ld_min, mode} !== {1'b1, 5'd7, 6'd30, 2'd0}) begin
         n_fails++;
         $display("FAIL same_cycle_mode_wins: got load=%b hr=%0d min=%0d mode=%0d required load=1 hr=7 min=30 mode=0",
                  load, ld_hr, ld_min, mode);
      end
      btn_mode = 1'b0; btn_inc = 1'b0;
      step();
   endtask

   task automatic test_timeout();
      btn_mode = 1'b1; step(); btn_mode = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         n_checks++;
         if ({mode, load} !== {2'd1, 1'b0}) begin
            n_fails++;
            $display("FAIL timeout_hold c=%0d: got mode=%0d load=%b required mode=1 load=0", c, mode, load);
         end
         step();
      end
      n_checks++;
      if ({mode, load} !== {2'd0, 1'b0}) begin
         n_fails++;
         $display("FAIL timeout_exit: got mode=%0d load=%b required mode=0 load=0", mode, load);
      end
      btn_mode = 1'b1; step(); btn_mode = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         btn_inc = (c == 10);
         n_checks++;
         if ({mode, load} !== {2'd1, 1'b0}) begin
            n_fails++;
            $display("FAIL timeout_restart c=%0d: got mode=%0d load=%b required mode=1 load=0", c, mode, load);
         end
         step();
      end
      btn_inc = 1'b0;
      n_checks++;
      if ({mode, load} !== {2'd0, 1'b0}) begin
         n_fails++;
         $display("FAIL timeout_restart_exit: got mode=%0d load=%b required mode=0 load=0", mode, load);
      end
   endtask

   task automatic test_reset_mid_edit();
      cur_hr = 5'd3; cur_min = 6'd4;
      press_mode();
      press_mode();
      press_inc();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (got !== 16'h0000) begin
         n_fails++;
         $display("FAIL reset_mid_edit: got=%h required=%h", got, 16'h0000);
      end
      for (int c = 1; c <= 8; c++) begin
         step();
         n_checks++;
         if ({load, mode} !== 3'b000) begin
            n_fails++;
            $display("FAIL reset_no_load c=%0d: got load=%b mode=%0d required load=0 mode=0", c, load, mode);
         end
      end
   endtask

   task automatic test_random();
      int pm, pi;
      rst = 1'b1; step(); rst = 1'b0;
      pm = 8; pi = 3;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            pm = int'($urandom_range(2, 30));
            pi = int'($urandom_range(2, 12));
         end
         if ($urandom_range(0, pm) == 0) btn_mode = ~btn_mode;
         if ($urandom_range(0, pi) == 0) btn_inc = ~btn_inc;
         if ($urandom_range(0, 15) == 0) begin
            cur_hr  = 5'($urandom_range(0, 23));
            cur_min = 6'($urandom_range(0, 59));
         end
         rst = ($urandom_range(0, 499) == 0);
         step();
         n_checks++;
         if (got !== model_out()) begin
            n_fails++;
            $display("FAIL random_vs_model c=%0d: got=%h required=%h", c, got, model_out());
         end
         n_checks++;
         if (sec_tick && (load || mode != 2'd0)) begin
            n_fails++;
            $display("FAIL random_tick_exclusive c=%0d: got tick=%b load=%b mode=%0d required no tick", c, sec_tick, load, mode);
         end
      end
      rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
   endtask

   initial begin
      test_reset();
      test_idle_ticks();
      test_edit_sequence();
      test_held_inc();
      test_same_cycle();
      test_timeout();
      test_reset_mid_edit();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
